// File: rtl/mux_4_1_rr_arb_if.sv
// Requester/consumer bundle for the shared 4:1 mux: request vector and data in, grant, select and muxed word out.
// master = requester/consumer side, slave = arbiter side.
interface mux_4_1_rr_arb_if #(
    parameter int DW = 8
);
    logic [3:0]      req_in;
    logic [4*DW-1:0] d_in;
    logic [3:0]      gnt_out;
    logic [1:0]      sel_out;
    logic            valid_out;
    logic [DW-1:0]   y_out;

    modport master (
        output req_in, d_in,
        input  gnt_out, sel_out, valid_out, y_out
    );

    modport slave (
        input  req_in, d_in,
        output gnt_out, sel_out, valid_out, y_out
    );
endinterface

// File: rtl/mux_4_1_rr_arb.sv
// Round-robin arbiter sharing one 4:1 data mux between four requesters, tenure capped at MAX_HOLD cycles.
// Latency: request sampled at edge N gives a registered grant after edge N; y_out is combinational from it.
// Backpressure: none; a requester holds req until served and releases by dropping req or hitting MAX_HOLD.
module mux_4_1_rr_arb #(
    parameter int DW       = 8,
    parameter int MAX_HOLD = 4,
    parameter int CW       = 8
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    mux_4_1_rr_arb_if.slave    bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state;
    logic [3:0]      gnt;
    logic [1:0]      sel;
    logic            valid;
    logic [CW-1:0]   cnt;
    logic [1:0]      last;

    logic [1:0]      base;
    logic [1:0]      idx;
    logic            win_vld;
    logic [1:0]      win_idx;
    logic            release_now;

    // Search starts after the last-served index while idle, after the owner while granted;
    // offset 4 wraps back to the base itself, so it is checked last.
    always_comb begin
        base    = (state == IDLE) ? last : sel;
        win_vld = 1'b0;
        win_idx = 2'd0;
        idx     = 2'd0;
        for (int i = 4; i >= 1; i--) begin
            idx = base + 2'(i);
            if (bus.req_in[idx]) begin
                win_vld = 1'b1;
                win_idx = idx;
            end
        end
    end

    assign release_now = !bus.req_in[sel] || (cnt == CW'(MAX_HOLD - 1));

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
            gnt   <= 4'b0000;
            sel   <= 2'd0;
            valid <= 1'b0;
            cnt   <= '0;
            last  <= 2'd3;
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        gnt   <= 4'b0001 << win_idx;
                        sel   <= win_idx;
                        valid <= 1'b1;
                        cnt   <= '0;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        last <= sel;
                        if (win_vld) begin
                            gnt <= 4'b0001 << win_idx;
                            sel <= win_idx;
                            cnt <= '0;
                        end else begin
                            gnt   <= 4'b0000;
                            valid <= 1'b0;
                            cnt   <= '0;
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt_out   = gnt;
    assign bus.sel_out   = sel;
    assign bus.valid_out = valid;
    assign bus.y_out     = valid ? bus.d_in[sel*DW +: DW] : '0;

endmodule

// File: tb/tb_mux_4_1_rr_arb.sv
// Directed bench for mux_4_1_rr_arb with MAX_HOLD=4 and d_in slice i = 8'hA0+i.
module tb_mux_4_1_rr_arb;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       valid;
    } vec_t;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    vec_t tbl_a[$];
    vec_t tbl_b[$];

    mux_4_1_rr_arb_if #(.DW(8)) bus ();

    mux_4_1_rr_arb #(.DW(8), .MAX_HOLD(4), .CW(8)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [3:0] q, input logic [3:0] g,
                                input logic [1:0] s, input logic v);
        vec_t t;
        t.rst_n = r;
        t.req   = q;
        t.gnt   = g;
        t.sel   = s;
        t.valid = v;
        return t;
    endfunction

    task automatic step(input vec_t v, input string name);
        logic [7:0]  ey;
        logic [14:0] act;
        logic [14:0] exp;
        rst_n      = v.rst_n;
        bus.req_in = v.req;
        @(posedge clk);
        #1;
        ey  = v.valid ? (8'hA0 + {6'b000000, v.sel}) : 8'h00;
        exp = {v.gnt, v.sel, v.valid, ey};
        act = {bus.gnt_out, bus.sel_out, bus.valid_out, bus.y_out};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got gnt=%b sel=%0d valid=%b y=%h, want gnt=%b sel=%0d valid=%b y=%h",
                     name, act[14:11], act[10:9], act[8], act[7:0],
                     v.gnt, v.sel, v.valid, ey);
        end
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        rst_n      = 1'b0;
        bus.req_in = 4'b0000;
        bus.d_in   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

        // Reset, five idle cycles, then everyone requests: requester 0 first.
        tbl_a.push_back(mk(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0));
        for (int i = 0; i < 5; i++)
            tbl_a.push_back(mk(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0));
        tbl_a.push_back(mk(1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1));

        // Idle drop from owner 2, rotation restart, handoffs, reset mid-grant.
        tbl_b.push_back(mk(1'b1, 4'b0000, 4'b0000, 2'd2, 1'b0));
        tbl_b.push_back(mk(1'b1, 4'b0101, 4'b0001, 2'd0, 1'b1));
        tbl_b.push_back(mk(1'b1, 4'b0101, 4'b0001, 2'd0, 1'b1));
        tbl_b.push_back(mk(1'b1, 4'b0101, 4'b0001, 2'd0, 1'b1));
        tbl_b.push_back(mk(1'b1, 4'b0101, 4'b0001, 2'd0, 1'b1));
        tbl_b.push_back(mk(1'b1, 4'b0101, 4'b0100, 2'd2, 1'b1));
        tbl_b.push_back(mk(1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1));
        tbl_b.push_back(mk(1'b1, 4'b1010, 4'b0010, 2'd1, 1'b1));
        tbl_b.push_back(mk(1'b1, 4'b1000, 4'b1000, 2'd3, 1'b1));
        tbl_b.push_back(mk(1'b1, 4'b1000, 4'b1000, 2'd3, 1'b1));
        tbl_b.push_back(mk(1'b0, 4'b1000, 4'b0000, 2'd0, 1'b0));
        tbl_b.push_back(mk(1'b1, 4'b1000, 4'b1000, 2'd3, 1'b1));
        tbl_b.push_back(mk(1'b0, 4'b1001, 4'b0000, 2'd0, 1'b0));
        tbl_b.push_back(mk(1'b1, 4'b1001, 4'b0001, 2'd0, 1'b1));
        tbl_b.push_back(mk(1'b1, 4'b0110, 4'b0010, 2'd1, 1'b1));
        tbl_b.push_back(mk(1'b1, 4'b0011, 4'b0010, 2'd1, 1'b1));
        tbl_b.push_back(mk(1'b1, 4'b0000, 4'b0000, 2'd1, 1'b0));

        foreach (tbl_a[i])
            step(tbl_a[i], $sformatf("reset_idle_%0d", i));

        // Full contention: 4-cycle tenures rotating 0,1,2,3,0 with no gap.
        for (int j = 1; j < 20; j++) begin
            logic [1:0] own;
            own = 2'((j / 4) % 4);
            step(mk(1'b1, 4'b1111, 4'b0001 << own, own, 1'b1), $sformatf("rotate_%0d", j));
        end

        // Lone requester 2 is regranted back-to-back past the hold limit.
        for (int j = 0; j < 10; j++)
            step(mk(1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1), $sformatf("lone_%0d", j));

        foreach (tbl_b[i])
            step(tbl_b[i], $sformatf("seq_%0d", i));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
